// File: rtl/bypass_buffer_mp_if.sv
// Port bundle for bypass_buffer_mp: writeback channels, invalidate/flush and lookup ports.
// hit_count exists only when BYPASS_STATS_EN is defined.
interface bypass_buffer_mp_if #(
  parameter int DEPTH  = 3,
  parameter int NUM_WB = 2,
  parameter int NUM_RD = 2,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // wb_valid qualifies each channel for one cycle; there is no ready, so writes
  // are never backpressured and the oldest entries are simply overwritten.
  logic                       flush;
  logic [NUM_WB-1:0]          wb_valid;
  logic [NUM_WB*TAG_W-1:0]    wb_tag;
  logic [NUM_WB*DATA_W-1:0]   wb_data;
  logic                       free_valid;
  logic [TAG_W-1:0]           free_tag;
  logic [NUM_RD*TAG_W-1:0]    rd_tag;
  logic [NUM_RD-1:0]          rd_hit;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [OCC_W-1:0]           occupancy;
`ifdef BYPASS_STATS_EN
  logic [31:0]                hit_count;

  modport master (output flush, wb_valid, wb_tag, wb_data, free_valid, free_tag, rd_tag,
                  input  rd_hit, rd_data, occupancy, hit_count);
  modport slave  (input  flush, wb_valid, wb_tag, wb_data, free_valid, free_tag, rd_tag,
                  output rd_hit, rd_data, occupancy, hit_count);
`else
  modport master (output flush, wb_valid, wb_tag, wb_data, free_valid, free_tag, rd_tag,
                  input  rd_hit, rd_data, occupancy);
  modport slave  (input  flush, wb_valid, wb_tag, wb_data, free_valid, free_tag, rd_tag,
                  output rd_hit, rd_data, occupancy);
`endif
endinterface

// File: rtl/bypass_buffer_mp.sv
// Multi-port bypass buffer: circular store of the DEPTH newest writeback results with
// NUM_RD zero-latency tag lookups. Optional hit counter under macro BYPASS_STATS_EN.
module bypass_buffer_mp #(
  parameter int DEPTH  = 3,
  parameter int NUM_WB = 2,
  parameter int NUM_RD = 2,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  bypass_buffer_mp_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(NUM_WB + 1);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  phys_rd;
    logic [DATA_W-1:0] result;
  } bypass_entry_t;

  bypass_entry_t     entries_q [DEPTH];
  bypass_entry_t     entries_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [NUM_WB-1:0] wb_acc;
  logic [PTR_W-1:0]  wb_slot [NUM_WB];
  logic [CNT_W-1:0]  acc_cnt;
  logic [NUM_RD-1:0] hit;
  logic [DATA_W-1:0] hit_data [NUM_RD];

  // Both operands stay below DEPTH, so one conditional subtract gives the modulo.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    wb_acc  = '0;
    acc_cnt = '0;
    for (int c = 0; c < NUM_WB; c++) begin
      wb_acc[c]  = bus.wb_valid[c] && (bus.wb_tag[c*TAG_W +: TAG_W] != '0);
      wb_slot[c] = ptr_add(wr_ptr_q, 32'(acc_cnt));
      if (wb_acc[c]) acc_cnt = acc_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    entries_d = entries_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (bus.free_valid && entries_q[e].phys_rd == bus.free_tag) entries_d[e].valid = 1'b0;
    end
    // Writes land after invalidation so a same-cycle rewrite of a freed tag survives.
    for (int c = 0; c < NUM_WB; c++) begin
      if (wb_acc[c]) begin
        entries_d[wb_slot[c]].valid   = 1'b1;
        entries_d[wb_slot[c]].phys_rd = bus.wb_tag[c*TAG_W +: TAG_W];
        entries_d[wb_slot[c]].result  = bus.wb_data[c*DATA_W +: DATA_W];
      end
    end
    wr_ptr_d = ptr_add(wr_ptr_q, 32'(acc_cnt));
    if (bus.flush) begin
      for (int e = 0; e < DEPTH; e++) entries_d[e].valid = 1'b0;
      wr_ptr_d = '0;
    end
    occ_d = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (entries_d[e].valid) occ_d = occ_d + OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) entries_q[e] <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) entries_q[e] <= entries_d[e];
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Scan oldest-to-newest then channels low-to-high; the last match is the newest copy.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      logic [TAG_W-1:0] tag;
      logic [PTR_W-1:0] idx;
      tag         = bus.rd_tag[p*TAG_W +: TAG_W];
      hit[p]      = 1'b0;
      hit_data[p] = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        idx = ptr_add(wr_ptr_q, 32'(DEPTH - k));
        if (entries_q[idx].valid && entries_q[idx].phys_rd == tag && tag != '0) begin
          hit[p]      = 1'b1;
          hit_data[p] = entries_q[idx].result;
        end
      end
      for (int c = 0; c < NUM_WB; c++) begin
        if (wb_acc[c] && bus.wb_tag[c*TAG_W +: TAG_W] == tag) begin
          hit[p]      = 1'b1;
          hit_data[p] = bus.wb_data[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    bus.rd_hit = hit;
    for (int p = 0; p < NUM_RD; p++) bus.rd_data[p*DATA_W +: DATA_W] = hit_data[p];
  end

  assign bus.occupancy = occ_q;

`ifdef BYPASS_STATS_EN
  logic [31:0] hit_count_q;
  logic [32:0] hit_sum;

  always_comb begin
    hit_sum = {1'b0, hit_count_q};
    for (int p = 0; p < NUM_RD; p++) begin
      if (hit[p]) hit_sum = hit_sum + 33'd1;
    end
  end

  // Survives flush on purpose: it tracks lifetime forwarding, not buffer contents.
  always_ff @(posedge clk) begin
    if (rst)             hit_count_q <= '0;
    else if (hit_sum[32]) hit_count_q <= '1;
    else                 hit_count_q <= hit_sum[31:0];
  end

  assign bus.hit_count = hit_count_q;
`endif
endmodule

// File: tb/tb_bypass_buffer_mp.sv
// Directed bench for bypass_buffer_mp (DEPTH=3, NUM_WB=2, NUM_RD=2) with a queue-based scoreboard.
module tb_bypass_buffer_mp;
  localparam int DEPTH  = 3;
  localparam int NUM_WB = 2;
  localparam int NUM_RD = 2;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int EXP_W  = NUM_RD + NUM_RD*DATA_W + OCC_W;

  logic clk = 1'b0;
  logic rst;

  bypass_buffer_mp_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .NUM_RD(NUM_RD),
                        .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  bypass_buffer_mp #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .NUM_RD(NUM_RD),
                     .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [EXP_W-1:0] exp_q [$];
  string            name_q [$];
  int               n_vec = 0;
  int               n_err = 0;
  bit               chk_pend = 1'b0;

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.flush      = 1'b0;
    bus.free_valid = 1'b0;
    bus.wb_valid   = '0;
  endtask

  task automatic set_wb(input logic [1:0] v, input logic [5:0] t0, input logic [31:0] d0,
                        input logic [5:0] t1, input logic [31:0] d1);
    bus.wb_valid = v;
    bus.wb_tag   = {t1, t0};
    bus.wb_data  = {d1, d0};
  endtask

  task automatic set_rd(input logic [5:0] t0, input logic [5:0] t1);
    bus.rd_tag = {t1, t0};
  endtask

  task automatic expect_lk(input string nm, input logic [1:0] hit, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [OCC_W-1:0] occ);
    exp_q.push_back({hit, d1, d0, occ});
    name_q.push_back(nm);
    chk_pend = 1'b1;
    next_cycle();
  endtask

`ifdef BYPASS_STATS_EN
  task automatic chk_hc(input string nm, input logic [31:0] exp_v);
    n_vec++;
    if (bus.hit_count !== exp_v) begin
      n_err++;
      $display("FAIL %s: hit_count got %0d want %0d", nm, bus.hit_count, exp_v);
    end
  endtask
`endif

  // monitor: compares whenever a lookup vector is presented
  always @(negedge clk) begin
    if (chk_pend) begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] act;
      string            nm;
      chk_pend = 1'b0;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: vector presented with no expected entry");
      end else begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {bus.rd_hit, bus.rd_data, bus.occupancy};
        if (act !== e) begin
          n_err++;
          $display("FAIL %s: got hit=%b data1=%h data0=%h occ=%0d, want hit=%b data1=%h data0=%h occ=%0d",
                   nm, act[EXP_W-1 -: 2], act[OCC_W+32 +: 32], act[OCC_W +: 32], act[OCC_W-1:0],
                   e[EXP_W-1 -: 2], e[OCC_W+32 +: 32], e[OCC_W +: 32], e[OCC_W-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.free_valid = 1'b0;
    bus.free_tag   = '0;
    bus.wb_valid   = '0;
    bus.wb_tag     = '0;
    bus.wb_data    = '0;
    bus.rd_tag     = '0;
    next_cycle();

    set_rd(5, 5);
    expect_lk("reset_miss", 2'b00, 32'h0, 32'h0, 0);

    set_wb(2'b11, 5, 32'hAA, 5, 32'hBB); set_rd(5, 7);
    expect_lk("fwd_dup", 2'b01, 32'hBB, 32'h0, 0);

    set_wb(2'b11, 7, 32'h11, 8, 32'h22); set_rd(5, 7);
    expect_lk("wrap_fwd", 2'b11, 32'hBB, 32'h11, 2);

    set_wb(2'b01, 9, 32'h33, 0, 32'h0); set_rd(8, 9);
    expect_lk("fwd_ch0", 2'b11, 32'h22, 32'h33, 3);

    set_rd(5, 9);
    expect_lk("overwritten", 2'b10, 32'h0, 32'h33, 3);

    set_wb(2'b01, 0, 32'hFF, 0, 32'h0); set_rd(0, 7);
    expect_lk("tag0_drop", 2'b10, 32'h0, 32'h11, 3);

    set_rd(0, 8);
    expect_lk("tag0_after", 2'b10, 32'h0, 32'h22, 3);

    bus.flush = 1'b1; set_wb(2'b01, 6, 32'h30, 0, 32'h0); set_rd(6, 9);
    expect_lk("flush_cycle", 2'b11, 32'h30, 32'h33, 3);

    set_rd(6, 9);
    expect_lk("post_flush", 2'b00, 32'h0, 32'h0, 0);

    set_wb(2'b01, 4, 32'h10, 0, 32'h0); set_rd(4, 0);
    expect_lk("wr_tag4", 2'b01, 32'h10, 32'h0, 0);

    bus.free_valid = 1'b1; bus.free_tag = 4; set_wb(2'b01, 4, 32'h20, 0, 32'h0); set_rd(4, 4);
    expect_lk("free_wr_same", 2'b11, 32'h20, 32'h20, 1);

    set_rd(4, 0);
    expect_lk("free_wr_after", 2'b01, 32'h20, 32'h0, 1);

    set_wb(2'b11, 12, 32'h1, 12, 32'h2); set_rd(12, 4);
    expect_lk("dup_fwd", 2'b11, 32'h2, 32'h20, 1);

    set_rd(12, 13);
    expect_lk("dup_stored", 2'b01, 32'h2, 32'h0, 3);

    bus.free_valid = 1'b1; bus.free_tag = 12; set_rd(12, 4);
    expect_lk("free_same_cycle", 2'b11, 32'h2, 32'h20, 3);

    set_rd(12, 4);
    expect_lk("free_after", 2'b10, 32'h0, 32'h20, 1);

    rst = 1'b1; bus.flush = 1'b1; set_rd(0, 0);
    next_cycle();
    set_rd(4, 4);
    expect_lk("rst_clear", 2'b00, 32'h0, 32'h0, 0);

`ifdef BYPASS_STATS_EN
    rst = 1'b1; set_rd(0, 0);
    next_cycle();
    chk_hc("hc_reset", 0);
    set_wb(2'b11, 10, 32'hA, 11, 32'hB);
    next_cycle();
    set_rd(10, 11);
    repeat (3) next_cycle();
    set_rd(0, 0);
    chk_hc("hc_six", 6);
    bus.flush = 1'b1;
    next_cycle();
    chk_hc("hc_flush_keeps", 6);
    rst = 1'b1;
    next_cycle();
    chk_hc("hc_rst_clears", 0);
`endif

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected entries never checked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
